// File: rtl/ext_bus_arbiter_n.sv
// EXT bus arbiter: parks the OPB bridge on the bus and round-robins grants among external masters.
// Optional hold-timeout preemption of external masters is built when EXT_ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// PARK    | OPB bridge owns the EXT bus, no external grant
// GRANT   | one external master granted, OPB accesses to the window retried
// RELEASE | one-cycle turnaround, nobody drives the bus
module ext_bus_arbiter_n #(
  parameter int         NUM_MASTERS = 2,
  parameter int         ID_W        = 1,
  parameter logic [6:0] WIN_BASE    = 7'h10,
  parameter logic [6:0] WIN_SIZE    = 7'h16,
  parameter int         MAX_HOLD    = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   opb_select,
  input  logic [0:31]            opb_abus,
  input  logic [NUM_MASTERS-1:0] ext_br_n,
  output logic [NUM_MASTERS-1:0] ext_bg_n,
  output logic                   sl_retry,
  output logic                   opb,
  output logic [ID_W-1:0]        grant_id
);

  if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("NUM_MASTERS must be 1..8");
  end
  if ((1 << ID_W) < NUM_MASTERS) begin : g_bad_id_w
    $error("ID_W too narrow for NUM_MASTERS");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
    $error("MAX_HOLD must be 2..65535");
  end

  typedef enum logic [1:0] {
    PARK    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Window end is computed in 8 bits so BASE+SIZE-1 cannot wrap.
  localparam logic [7:0] WIN_LO = {1'b0, WIN_BASE};
  localparam logic [7:0] WIN_HI = WIN_LO + {1'b0, WIN_SIZE} - 8'd1;

  state_t                 state;
  logic [NUM_MASTERS-1:0] br_s;
  logic [NUM_MASTERS-1:0] req_v;
  logic [NUM_MASTERS-1:0] win_bg_n;
  logic [ID_W-1:0]        rr;
  logic [ID_W-1:0]        rr_next;
  logic [ID_W-1:0]        win;
  logic                   any_req;
  logic                   hit;
  logic [7:0]             addr_hi;
  logic                   unused_abus;
  int                     scan_idx;

  assign addr_hi     = {1'b0, opb_abus[0:6]};
  assign hit         = opb_select && (addr_hi >= WIN_LO) && (addr_hi <= WIN_HI);
  assign unused_abus = ^opb_abus[7:31];

`ifdef EXT_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0]            hold_cnt;
  logic [NUM_MASTERS-1:0] mask;
  assign req_v = ~br_s & ~mask;
`else
  assign req_v = ~br_s;
`endif

  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      scan_idx = int'(rr) + i;
      if (scan_idx >= NUM_MASTERS) scan_idx = scan_idx - NUM_MASTERS;
      if (!any_req && req_v[scan_idx]) begin
        any_req = 1'b1;
        win     = ID_W'(scan_idx);
      end
    end
  end

  assign win_bg_n = ~(NUM_MASTERS'(1) << win);
  assign rr_next  = (grant_id == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PARK;
      br_s     <= '1;
      ext_bg_n <= '1;
      opb      <= 1'b0;
      sl_retry <= 1'b0;
      grant_id <= '0;
      rr       <= '0;
`ifdef EXT_ARB_TIMEOUT_EN
      hold_cnt <= '0;
      mask     <= '0;
`endif
    end else begin
      br_s <= ext_br_n;
`ifdef EXT_ARB_TIMEOUT_EN
      // A preempted master stays out of arbitration until it lets go once.
      mask <= mask & ~br_s;
`endif
      case (state)
        PARK: begin
          sl_retry <= 1'b0;
          if (any_req && !hit) begin
            state    <= GRANT;
            ext_bg_n <= win_bg_n;
            grant_id <= win;
            opb      <= 1'b0;
`ifdef EXT_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            opb      <= 1'b1;
            ext_bg_n <= '1;
          end
        end
        GRANT: begin
          sl_retry <= hit;
          opb      <= 1'b0;
          if (br_s[grant_id]) begin
            state    <= RELEASE;
            ext_bg_n <= '1;
            rr       <= rr_next;
          end
`ifdef EXT_ARB_TIMEOUT_EN
          else if (hit && hold_cnt >= HOLD_LAST) begin
            state    <= RELEASE;
            ext_bg_n <= '1;
            rr       <= rr_next;
            mask     <= (mask & ~br_s) | (NUM_MASTERS'(1) << grant_id);
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
`endif
        end
        RELEASE: begin
          sl_retry <= hit;
          opb      <= 1'b1;
          ext_bg_n <= '1;
          state    <= PARK;
        end
        default: begin
          state    <= PARK;
          opb      <= 1'b1;
          ext_bg_n <= '1;
          sl_retry <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_arbiter_n.sv
// Directed-vector bench for ext_bus_arbiter_n with two masters and MAX_HOLD=8.
module tb_ext_bus_arbiter_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        opb_select;
  logic [31:0] opb_abus;
  logic [1:0]  ext_br_n;
  logic [1:0]  ext_bg_n;
  logic        sl_retry;
  logic        opb;
  logic        grant_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ext_bus_arbiter_n #(
    .NUM_MASTERS(2),
    .ID_W       (1),
    .WIN_BASE   (7'h10),
    .WIN_SIZE   (7'h16),
    .MAX_HOLD   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opb_select(opb_select),
    .opb_abus  (opb_abus),
    .ext_br_n  (ext_br_n),
    .ext_bg_n  (ext_bg_n),
    .sl_retry  (sl_retry),
    .opb       (opb),
    .grant_id  (grant_id)
  );

  typedef struct {
    logic [1:0]  br;
    logic        sel;
    logic [31:0] abus;
    logic [1:0]  bg;
    logic        o;
    logic        r;
    logic        g;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(logic [1:0] br, logic sel, logic [31:0] abus,
                              logic [1:0] bg, logic o, logic r, logic g);
    vec_t v;
    v.br = br; v.sel = sel; v.abus = abus; v.bg = bg; v.o = o; v.r = r; v.g = g;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk1("no_overlap", opb & (ext_bg_n != 2'b11), 1'b0);
    chk1("bg_onehot", ext_bg_n == 2'b00, 1'b0);
  endtask

  task automatic drive(input logic [1:0] br, input logic sel, input logic [31:0] a);
    ext_br_n   = br;
    opb_select = sel;
    opb_abus   = a;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] bg, input logic o,
                            input logic r, input logic g);
    chk2({tag, "_bg"}, ext_bg_n, bg);
    chk1({tag, "_opb"}, opb, o);
    chk1({tag, "_retry"}, sl_retry, r);
    chk1({tag, "_gid"}, grant_id, g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               br     sel   abus           bg     opb   retry gid
    vecs[0]  = mk(2'b11, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(2'b10, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(2'b10, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(2'b10, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(2'b11, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(2'b11, 1'b0, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(2'b11, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(2'b00, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(2'b00, 1'b0, 32'h0000_0000, 2'b01, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(2'b00, 1'b0, 32'h0000_0000, 2'b01, 1'b0, 1'b0, 1'b1);
    vecs[10] = mk(2'b00, 1'b0, 32'h0000_0000, 2'b01, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(2'b10, 1'b0, 32'h0000_0000, 2'b01, 1'b0, 1'b0, 1'b1);
    vecs[12] = mk(2'b10, 1'b0, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(2'b00, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 1'b0, 1'b1);
    vecs[14] = mk(2'b00, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(2'b00, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(2'b00, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[17] = mk(2'b01, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[18] = mk(2'b01, 1'b0, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b0);
    vecs[19] = mk(2'b00, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 1'b0, 1'b0);
    vecs[20] = mk(2'b00, 1'b0, 32'h0000_0000, 2'b01, 1'b0, 1'b0, 1'b1);
    vecs[21] = mk(2'b00, 1'b1, 32'h2400_0000, 2'b01, 1'b0, 1'b1, 1'b1);
    vecs[22] = mk(2'b00, 1'b1, 32'h0000_0000, 2'b01, 1'b0, 1'b0, 1'b1);
    vecs[23] = mk(2'b00, 1'b0, 32'h2400_0000, 2'b01, 1'b0, 1'b0, 1'b1);
    vecs[24] = mk(2'b10, 1'b1, 32'h2400_0000, 2'b01, 1'b0, 1'b1, 1'b1);
    vecs[25] = mk(2'b10, 1'b1, 32'h2400_0000, 2'b11, 1'b0, 1'b1, 1'b1);
    vecs[26] = mk(2'b10, 1'b1, 32'h2400_0000, 2'b11, 1'b1, 1'b1, 1'b1);
    vecs[27] = mk(2'b10, 1'b1, 32'h2000_0000, 2'b11, 1'b1, 1'b0, 1'b1);
    vecs[28] = mk(2'b10, 1'b1, 32'h4BFF_FFFC, 2'b11, 1'b1, 1'b0, 1'b1);
    vecs[29] = mk(2'b10, 1'b1, 32'h4C00_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[30] = mk(2'b11, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[31] = mk(2'b11, 1'b0, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b0);
    vecs[32] = mk(2'b11, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 1'b0, 1'b0);

    reset = 1'b1;
    drive(2'b11, 1'b0, 32'h0);
    tick();
    tick();
    expect_out("reset", 2'b11, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].br, vecs[i].sel, vecs[i].abus);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].bg, vecs[i].o, vecs[i].r, vecs[i].g);
    end

`ifdef EXT_ARB_TIMEOUT_EN
    // Master 0 holds the bus while an in-window access waits: preempt after 8 grant cycles.
    drive(2'b10, 1'b0, 32'h0);
    tick();
    tick();
    expect_out("to_grant", 2'b10, 1'b0, 1'b0, 1'b0);
    drive(2'b10, 1'b1, 32'h2000_0000);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk2($sformatf("to_hold%0d_bg", k), ext_bg_n, 2'b10);
    end
    tick();
    expect_out("to_drop", 2'b11, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("to_park", 2'b11, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("to_hit", 2'b11, 1'b1, 1'b0, 1'b0);
    drive(2'b10, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("to_masked%0d", k), 2'b11, 1'b1, 1'b0, 1'b0);
    end
    drive(2'b11, 1'b0, 32'h0);
    tick();
    expect_out("to_let_go", 2'b11, 1'b1, 1'b0, 1'b0);
    drive(2'b10, 1'b0, 32'h0);
    tick();
    expect_out("to_rereq", 2'b11, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("to_regrant", 2'b10, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    expect_out("to_end", 2'b11, 1'b1, 1'b0, 1'b0);
`else
    // Without the timeout a grant outlasts any amount of OPB pressure.
    drive(2'b10, 1'b0, 32'h0);
    tick();
    tick();
    expect_out("np_grant", 2'b10, 1'b0, 1'b0, 1'b0);
    drive(2'b10, 1'b1, 32'h2000_0000);
    repeat (12) tick();
    expect_out("np_hold", 2'b10, 1'b0, 1'b1, 1'b0);
    drive(2'b11, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    expect_out("np_end", 2'b11, 1'b1, 1'b0, 1'b0);
`endif

    // Reset in the middle of master 1's tenure.
    drive(2'b01, 1'b0, 32'h0);
    tick();
    tick();
    expect_out("rst_pre", 2'b01, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    expect_out("rst_mid", 2'b11, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(2'b11, 1'b0, 32'h0);
    tick();
    expect_out("rst_post", 2'b11, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
